// File: rtl/my_store_merge.sv
// my_store_merge
//
// Store-path write merger sitting between the EX/MEM stage and the
// word-organised DRAM. Word stores go straight to a single WRITE cycle.
// Byte and halfword stores perform a read-modify-write: READ presents the
// word address, MERGE folds the new lanes into the returned word, and WRITE
// stores it back. The DRAM has no byte enables; this block is its only writer.
//
// Optional feature (macro STORE_LAST_WORD_FWD_EN):
//   Keeps a copy of the last written word and its address. A sub-word store
//   that hits that word merges into the copy and skips READ/MERGE entirely.
//   With the macro undefined every sub-word store takes the 3-cycle path.
//
// Ports:
//   cpu_clk      in   system clock, rising edge
//   cpu_rst      in   asynchronous active-high reset
//   st_req       in   store request, sampled only in IDLE
//   st_op        in   0 = ST_B, 1 = ST_H, 2 = ST_W, 3 = reserved (illegal)
//   st_addr      in   byte address
//   st_data      in   store data (ST_B uses [7:0], ST_H uses [15:0])
//   st_busy      out  high in every non-IDLE state (pipeline stall)
//   st_done      out  one-cycle pulse in the WRITE cycle
//   st_misalign  out  one-cycle pulse: request rejected, nothing written
//   dram_addr    out  registered DRAM word address
//   dram_rdata   in   synchronous read data, valid one cycle after dram_addr
//   dram_we      out  write strobe, high only in WRITE
//   dram_wdata   out  registered write word

module my_store_merge #(
  parameter int ADDR_W = 14
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              st_req,
  input  logic [1:0]        st_op,
  input  logic [31:0]       st_addr,
  input  logic [31:0]       st_data,
  output logic              st_busy,
  output logic              st_done,
  output logic              st_misalign,
  output logic [ADDR_W-1:0] dram_addr,
  input  logic [31:0]       dram_rdata,
  output logic              dram_we,
  output logic [31:0]       dram_wdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    MERGE = 2'd2,
    WRITE = 2'd3
  } state_t;

  localparam logic [1:0] OP_B = 2'd0;
  localparam logic [1:0] OP_H = 2'd1;
  localparam logic [1:0] OP_W = 2'd2;
  localparam logic [1:0] OP_X = 2'd3;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [1:0]          lane_q, lane_d;
  logic                half_q, half_d;
  logic [15:0]         data_q, data_d;
  logic                misalign_q, misalign_d;

  logic [ADDR_W-1:0]   word_addr;
  logic                illegal;
  logic                unused_addr_bits;

`ifdef STORE_LAST_WORD_FWD_EN
  logic [ADDR_W-1:0]   last_addr_q, last_addr_d;
  logic [31:0]         last_word_q, last_word_d;
  logic                last_vld_q, last_vld_d;
`endif

  // Replace the addressed byte or halfword of a 32-bit word. A halfword is
  // selected by lane[1] alone; alignment has already been checked.
  function automatic logic [31:0] merge_lanes(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic        half,
                                              input logic [15:0] data);
    logic [31:0] r;
    r = word;
    if (half) begin
      if (lane[1]) r[31:16] = data;
      else         r[15:0]  = data;
    end else begin
      case (lane)
        2'd0:    r[7:0]   = data[7:0];
        2'd1:    r[15:8]  = data[7:0];
        2'd2:    r[23:16] = data[7:0];
        default: r[31:24] = data[7:0];
      endcase
    end
    return r;
  endfunction

  assign word_addr = st_addr[ADDR_W+1:2];

  // Bits above the DRAM word address are not decoded by this block.
  assign unused_addr_bits = ^st_addr[31:ADDR_W+2];

  assign illegal = (st_op == OP_X) ||
                   ((st_op == OP_H) && st_addr[0]) ||
                   ((st_op == OP_W) && (st_addr[1:0] != 2'd0));

  // Next-state and datapath capture. Everything holds by default; the
  // misalign pulse defaults low so it lasts exactly one cycle.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    lane_d     = lane_q;
    half_d     = half_q;
    data_d     = data_q;
    misalign_d = 1'b0;
`ifdef STORE_LAST_WORD_FWD_EN
    last_addr_d = last_addr_q;
    last_word_d = last_word_q;
    last_vld_d  = last_vld_q;
`endif

    case (state_q)
      IDLE: begin
        if (st_req) begin
          if (illegal) begin
            misalign_d = 1'b1;
          end else if (st_op == OP_W) begin
            addr_d  = word_addr;
            wdata_d = st_data;
            state_d = WRITE;
          end else begin
            addr_d = word_addr;
            lane_d = st_addr[1:0];
            half_d = (st_op == OP_H);
            data_d = st_data[15:0];
`ifdef STORE_LAST_WORD_FWD_EN
            // Hit on the last written word: its contents are already known,
            // so the DRAM read can be skipped.
            if (last_vld_q && (last_addr_q == word_addr)) begin
              wdata_d = merge_lanes(last_word_q, st_addr[1:0],
                                    (st_op == OP_H), st_data[15:0]);
              state_d = WRITE;
            end else begin
              state_d = READ;
            end
`else
            state_d = READ;
`endif
          end
        end
      end
      READ: begin
        state_d = MERGE;
      end
      MERGE: begin
        wdata_d = merge_lanes(dram_rdata, lane_q, half_q, data_q);
        state_d = WRITE;
      end
      WRITE: begin
        state_d = IDLE;
`ifdef STORE_LAST_WORD_FWD_EN
        last_addr_d = addr_q;
        last_word_d = wdata_q;
        last_vld_d  = 1'b1;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset clears every output-driving flop so
  // an abort leaves the DRAM interface quiet.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      lane_q     <= '0;
      half_q     <= 1'b0;
      data_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      lane_q     <= lane_d;
      half_q     <= half_d;
      data_q     <= data_d;
      misalign_q <= misalign_d;
    end
  end

`ifdef STORE_LAST_WORD_FWD_EN
  // Last-written-word copy used to bypass the read of a read-modify-write.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      last_addr_q <= '0;
      last_word_q <= '0;
      last_vld_q  <= 1'b0;
    end else begin
      last_addr_q <= last_addr_d;
      last_word_q <= last_word_d;
      last_vld_q  <= last_vld_d;
    end
  end
`endif

  assign st_busy     = (state_q != IDLE);
  assign st_done     = (state_q == WRITE);
  assign dram_we     = (state_q == WRITE);
  assign st_misalign = misalign_q;
  assign dram_addr   = addr_q;
  assign dram_wdata  = wdata_q;

endmodule
